// File: rtl/keypad_scan.sv
// keypad_scan: column scanner, debouncer and decoder for a 4x4 hex keypad.
// Accepted digits shift into a 32-bit register that feeds a multiplexed
// 7-segment display, newest digit in the least significant nibble.
module keypad_scan #(
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] div_value,
  input  logic        clear,
  input  logic [3:0]  row,
  output logic [3:0]  col,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic [31:0] dout
);

  typedef enum logic [1:0] {StIdle, StConfirm, StHeld, StRelease} state_e;

  localparam logic [4:0] DebTarget  = 5'(DEBOUNCE_SCANS);
  localparam bit         SingleScan = (DEBOUNCE_SCANS == 1);

  // Row synchronizer
  logic [3:0]  row_meta_q;
  logic [3:0]  row_sync_q;

  // Column timing
  logic [31:0] per_cnt_q;
  logic [31:0] per_last;
  logic        tick;
  logic        scan_done;
  logic [1:0]  col_idx_q;
  logic [3:0]  col_q;

  // Scan image, bit index is col*4 + row, pressed = 1
  logic [15:0] scan_img_q;
  logic [15:0] scan_full;

  // Scan classification
  logic [4:0]  hit_cnt;
  logic [3:0]  hit_idx;
  logic [3:0]  scan_key;
  logic        scan_none;
  logic        scan_single;

  // Debounce FSM
  state_e      state_q;
  logic [3:0]  cnt_q;
  logic [3:0]  cand_q;
  logic [4:0]  cnt_inc;
  logic        accept;

  // Registered outputs
  logic        key_valid_q;
  logic [3:0]  key_code_q;
  logic [31:0] dout_q;

  // Keypad legend; r selects the row, c the column.
  function automatic logic [3:0] decode_key(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    code = 4'h0;
    unique case ({r, c})
      4'b00_00: code = 4'h1;
      4'b00_01: code = 4'h2;
      4'b00_10: code = 4'h3;
      4'b00_11: code = 4'hA;
      4'b01_00: code = 4'h4;
      4'b01_01: code = 4'h5;
      4'b01_10: code = 4'h6;
      4'b01_11: code = 4'hB;
      4'b10_00: code = 4'h7;
      4'b10_01: code = 4'h8;
      4'b10_10: code = 4'h9;
      4'b10_11: code = 4'hC;
      4'b11_00: code = 4'h0;
      4'b11_01: code = 4'hF;
      4'b11_10: code = 4'hE;
      4'b11_11: code = 4'hD;
    endcase
    return code;
  endfunction

  // Two-stage synchronizer; idle rows read as all ones (nothing pressed).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_meta_q <= 4'hF;
      row_sync_q <= 4'hF;
    end else begin
      row_meta_q <= row;
      row_sync_q <= row_meta_q;
    end
  end

  // Period end; short periods are clamped so the rows get at least 2 settle clocks.
  always_comb begin
    per_last  = (div_value < 32'd4) ? 32'd3 : div_value - 32'd1;
    // >= so that shrinking div_value mid-period ends the period instead of wrapping
    tick      = (per_cnt_q >= per_last);
    scan_done = tick && (col_idx_q == 2'd3);
  end

  // Period counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      per_cnt_q <= '0;
    end else if (tick) begin
      per_cnt_q <= '0;
    end else begin
      per_cnt_q <= per_cnt_q + 32'd1;
    end
  end

  // Column index and one-hot-low drive, rotated together on each tick.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_idx_q <= 2'd0;
      col_q     <= 4'b1110;
    end else if (tick) begin
      col_idx_q <= col_idx_q + 2'd1;
      col_q     <= {col_q[2:0], col_q[3]};
    end
  end

  // Image including the column being sampled this cycle.
  always_comb begin
    scan_full = scan_img_q;
    scan_full[{col_idx_q, 2'b00} +: 4] = ~row_sync_q;
  end

  // Accumulate one column per tick; start empty after each full scan.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_img_q <= '0;
    end else if (scan_done) begin
      scan_img_q <= '0;
    end else if (tick) begin
      scan_img_q <= scan_full;
    end
  end

  // Count pressed keys and locate the (single) one.
  always_comb begin
    hit_cnt = '0;
    hit_idx = '0;
    for (int i = 0; i < 16; i++) begin
      if (scan_full[i]) begin
        hit_cnt = hit_cnt + 5'd1;
        hit_idx = 4'(i);
      end
    end
    scan_none   = (hit_cnt == 5'd0);
    scan_single = (hit_cnt == 5'd1);
    scan_key    = decode_key(hit_idx[1:0], hit_idx[3:2]);
  end

  // Accept fires on the scan that completes the required run of identical singles.
  always_comb begin
    cnt_inc = {1'b0, cnt_q} + 5'd1;
    accept  = 1'b0;
    if (scan_done && scan_single) begin
      case (state_q)
        StIdle:    accept = SingleScan;
        StConfirm: accept = (scan_key == cand_q) && (cnt_inc == DebTarget);
        default:   accept = 1'b0;
      endcase
    end
  end

  // Debounce FSM, advanced once per full scan; also owns key_valid and key_code.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      cand_q      <= '0;
      key_valid_q <= 1'b0;
      key_code_q  <= '0;
    end else begin
      key_valid_q <= accept;
      if (accept) begin
        key_code_q <= scan_key;
      end
      if (scan_done) begin
        unique case (state_q)
          StIdle: begin
            if (scan_single) begin
              cand_q  <= scan_key;
              cnt_q   <= 4'd1;
              state_q <= accept ? StHeld : StConfirm;
            end
          end
          StConfirm: begin
            if (scan_single && (scan_key == cand_q)) begin
              cnt_q <= cnt_inc[3:0];
              if (accept) begin
                state_q <= StHeld;
              end
            end else if (scan_single) begin
              // A different key restarts the run rather than aborting it.
              cand_q <= scan_key;
              cnt_q  <= 4'd1;
            end else begin
              state_q <= StIdle;
            end
          end
          StHeld: begin
            // Held keys never repeat; wait for a clean release.
            if (scan_none) begin
              cnt_q   <= 4'd1;
              state_q <= SingleScan ? StIdle : StRelease;
            end
          end
          StRelease: begin
            if (scan_none) begin
              cnt_q <= cnt_inc[3:0];
              if (cnt_inc == DebTarget) begin
                state_q <= StIdle;
              end
            end else begin
              state_q <= StHeld;
            end
          end
        endcase
      end
    end
  end

  // Digit shift register; a simultaneous clear keeps only the new digit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout_q <= '0;
    end else if (accept) begin
      dout_q <= {(clear ? 28'h0 : dout_q[27:0]), scan_key};
    end else if (clear) begin
      dout_q <= '0;
    end
  end

  assign col       = col_q;
  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;
  assign dout      = dout_q;

endmodule

// File: doc/keypad_scan.md
# keypad_scan

Scanner and decoder for a 4x4 hex keypad on a Pmod port, the input-side counterpart of the multiplexed 7-segment display driver. It drives keypad columns one at a time, samples the rows, debounces, and decodes a single pressed key to a 4-bit hex code. Accepted digits shift into a 32-bit register whose output connects directly to the display's `din`, so typed digits appear right-aligned on the eight digits.

## Interface
Parameters:
- `DEBOUNCE_SCANS`, default 4: number of consecutive full scans a key must be seen (press) or absent (release) before the state changes. Range 1..15.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `div_value`  in  32  clocks per column period P. Values below 4 are treated as 4.
- `clear`  in  1  synchronous; zeroes `dout`.
- `row`  in  4  keypad rows, active-low, pulled up externally. Asynchronous to `clk`.
- `col`  out  4  keypad column drive, active-low, one-hot-low.
- `key_valid`  out  1  one-cycle pulse when a key is accepted.
- `key_code`  out  4  hex code of the last accepted key. Held between accepts.
- `dout`  out  32  entered digits; newest digit in `[3:0]`.

## Operation
- **Row synchronizer:** `row` passes through a 2-FF synchronizer. Reset value of both stages is 4'hF.
- **Column timing:** a period counter counts 0..P-1. On count P-1 (the "tick"):
  - the synchronized rows are sampled into the current column's 4 bits of a 16-bit scan image (pressed = 1);
  - the column index advances 0→1→2→3→0;
  - `col` drives index c low: c=0 gives 4'b1110, c=3 gives 4'b0111.
- **Scan completion:** the tick at column 3 completes a full scan (4P clocks). The scan image is evaluated, then cleared.
- **Key decode** (row r, column c):
  - r0: 1, 2, 3, A
  - r1: 4, 5, 6, B
  - r2: 7, 8, 9, C
  - r3: 0, F, E, D
- **Scan classification:** exactly one bit set gives "single(k)". Zero bits gives "none". Two or more bits gives "multi".
- **FSM:** states IDLE, CONFIRM, HELD, RELEASE, with a scan counter `cnt` and a candidate key `cand`.
  - **IDLE:**
    - single(k): `cand`=k, `cnt`=1, go to CONFIRM. If `DEBOUNCE_SCANS`=1, accept immediately and go to HELD.
    - otherwise: stay in IDLE.
  - **CONFIRM:**
    - single(`cand`): `cnt`+1. When `cnt` reaches `DEBOUNCE_SCANS`, accept and go to HELD.
    - single(other): restart with the new candidate, `cnt`=1.
    - none or multi: go to IDLE.
  - **HELD:**
    - none: `cnt`=1, go to RELEASE. If `DEBOUNCE_SCANS`=1, go straight to IDLE.
    - anything else: stay in HELD. There is no auto-repeat.
  - **RELEASE:**
    - none: `cnt`+1. When `cnt` reaches `DEBOUNCE_SCANS`, go to IDLE.
    - any key: return to HELD.
- **Accept:**
  - `key_valid`=1 for one cycle.
  - `key_code`=`cand`.
  - `dout` <= {`dout[27:0]`, `cand`}. The oldest digit is discarded.
- **Clear:**
  - `clear` alone: `dout`=0.
  - `clear` in the same cycle as an accept: `dout` = {28'h0, `cand`}.
  - `clear` does not affect the FSM or `key_code`.
- **`div_value` changes:** take effect at the next tick. The counter compares with `>=` so that shrinking the value mid-period does not cause a wrap-around stall.

## Timing
- **Reset values:**
  - `col`=4'b1110
  - `key_valid`=0, `key_code`=0, `dout`=0
  - FSM in IDLE, all counters 0, scan image 0
- **Reset mid-operation:** any partial scan or debounce in progress is discarded. After `rst` deasserts, scanning restarts at column 0.
- **Row settle:** the sample at the tick reflects `row` from 2 clocks earlier. This gives at least P-2 ≥ 2 clocks of settle after a column change.
- **Accept latency:** `key_valid` rises 1 clock after the scan-completing tick of the `DEBOUNCE_SCANS`-th consecutive qualifying scan. `key_code` and `dout` update in the same cycle. The worst case from a stable press is (`DEBOUNCE_SCANS`+1)·4P + 3 clocks.
- **Re-press:** the minimum interval between two accepts of the same key is `DEBOUNCE_SCANS` press scans plus `DEBOUNCE_SCANS` release scans.

## Test plan
- **Single press:** `div_value`=4, `DEBOUNCE_SCANS`=4. Model a keypad that pulls row1 low while `col`=4'b1101; hold it 10 scans (160 clocks), then release. Required: exactly one `key_valid` pulse, `key_code`=5, `dout`=32'h0000_0005, first pulse within 80+3 clocks of the press.
- **Digit sequence:** press and release 1, 2, 3, A, F, 0, 9, 8, then one more key 7. Required: `dout`=32'h123A_F098 after 8 keys; after the 9th key `dout`=32'h23AF_0987.
- **Bounce rejection:**
  - Key 9 pressed on alternating scans for 8 scans: no `key_valid`.
  - Keys 4 and 6 pressed together for 10 scans: no `key_valid`.
- **Long hold and re-press:**
  - Hold D for 100 scans: exactly one pulse, `key_code`=4'hD.
  - Release for 2 scans, press again: no new pulse.
  - Release for 5 scans, press again: second pulse.
- **Reset and clear:**
  - Assert `rst` (low) in CONFIRM after 2 qualifying scans: `col`=4'b1110, `dout`=0, `key_valid`=0 immediately. After release of `rst`, holding the key needs 4 full new scans before it is accepted.
  - `clear` pulsed in the accept cycle of key C: `dout`=32'h0000_000C.
